// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall detection, multdiv launch/wait handshake and stall-cycle counter
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ctrl_dx,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        fd_uses_rt,
  input  logic        md_is_mult,
  input  logic        md_is_div,
  input  logic        md_ready,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        hold_pc_fd,
  output logic        hold_dx,
  output logic        nop_dx,
  output logic        nop_xm,
  output logic        md_wb,
  output logic        md_fault,
  output logic [31:0] stall_cycles
);
  localparam int CW = MD_TIMEOUT > 1 ? $clog2(MD_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_stall;
  logic          w_lu, w_start, w_unused;
  assign w_lu = ctrl_dx[13] & ctrl_dx[15] & (ctrl_dx[31:27] != 5'd0) &
                ((ctrl_dx[31:27] == fd_rs) | (fd_uses_rt & (ctrl_dx[31:27] == fd_rt)));
  assign w_start = (md_is_mult | md_is_div) & ~flush;
  assign w_unused = ^{ctrl_dx[26:16], ctrl_dx[14], ctrl_dx[12:0]};
  assign md_fault = r_state == FAULT;
  assign stall_cycles = r_stall;
  // next state, timeout counter and all combinational stall/launch outputs
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    hold_pc_fd = 1'b0;
    hold_dx = 1'b0;
    nop_dx = 1'b0;
    nop_xm = 1'b0;
    md_wb = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          ctrl_MULT = md_is_mult;
          ctrl_DIV = md_is_div & ~md_is_mult;
          hold_pc_fd = 1'b1;
          hold_dx = 1'b1;
          nop_xm = 1'b1;
          w_cnt_nxt = '0;
          w_state_nxt = BUSY;
        end else begin
          hold_pc_fd = w_lu;
          nop_dx = w_lu;
        end
      end
      BUSY: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (md_ready) begin
          md_wb = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt == CW'(MD_TIMEOUT - 1)) begin
          w_state_nxt = FAULT;
        end else begin
          hold_pc_fd = 1'b1;
          hold_dx = 1'b1;
          nop_xm = 1'b1;
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = FAULT;
    endcase
  end
  // state, timeout counter and stall-cycle performance counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_stall <= hold_pc_fd ? r_stall + 32'd1 : r_stall;
    end
  end
endmodule
